// File: rtl/mips_uarttx.sv
// ============================================================================
// Module      : mips_uarttx
// Description : FIFO-drained UART transmitter. It pops one word with a
//               show-ahead read and sends start, data LSB first, optional
//               even parity, then stop bit(s). Define MIPS_UARTTX_PARITY_EN
//               to compile in the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_uarttx #(
  parameter int S_WORD    = 8,
  parameter int BAUD_DIV  = 434,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [S_WORD-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy
);

  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int BAUD_W   = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int BIT_W    = $clog2(S_WORD + 1);
  localparam logic [BAUD_W-1:0] BIT_LOAD  = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] STOP_LOAD = BAUD_W'(STOP_LEN - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(S_WORD - 1);

`ifdef MIPS_UARTTX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [S_WORD-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
`ifdef MIPS_UARTTX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
`ifdef MIPS_UARTTX_PARITY_EN
    parity_d   = parity_q;
`endif
    fifo_rd_en = (state_q == IDLE) && !fifo_empty && rst;

    if (state_q != IDLE && baud_q != '0) begin
      baud_d = baud_q - BAUD_W'(1);
    end

    // Each branch acts only at the final cycle of the current bit period.
    case (state_q)
      IDLE: begin
        if (fifo_rd_en) begin
          shift_d   = fifo_rd_data;
          bit_cnt_d = '0;
          baud_d    = BIT_LOAD;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
`ifdef MIPS_UARTTX_PARITY_EN
          parity_d  = ^fifo_rd_data;
`endif
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          baud_d  = BIT_LOAD;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef MIPS_UARTTX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
            baud_d  = BIT_LOAD;
`else
            state_d = STOP;
            tx_d    = 1'b1;
            baud_d  = STOP_LOAD;
`endif
          end else begin
            tx_d    = shift_d[0];
            baud_d  = BIT_LOAD;
          end
        end
      end
`ifdef MIPS_UARTTX_PARITY_EN
      PARITY: begin
        if (baud_q == '0) begin
          state_d = STOP;
          tx_d    = 1'b1;
          baud_d  = STOP_LOAD;
        end
      end
`endif
      STOP: begin
        if (baud_q == '0) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef MIPS_UARTTX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef MIPS_UARTTX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: doc/mips_uarttx.md
# mips_uarttx

FIFO-drained UART transmitter. Sits on the read side of a `mips_fifosync` instance, takes words from it with a show-ahead pop, and serializes each word onto a single asynchronous line. The frame is start bit, data LSB first, optional parity, then stop bit(s). This is the CPU's console/debug output path: software writes bytes into the FIFO and this block empties it at line rate.

## Interface
- `S_WORD`, 8, data bits per frame; must equal the FIFO word width.
- `BAUD_DIV`, 434, clock cycles per bit (50 MHz / 115200); legal range ≥ 2.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_data`  in  S_WORD  FIFO head word, valid whenever `fifo_empty`=0 (show-ahead).
- `fifo_rd_en`  out  1  one-cycle pop strobe to the FIFO.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- FSM states: IDLE, START, DATA, PARITY (only if enabled), STOP.
- IDLE:
  - `fifo_rd_en` = (state==IDLE) & !`fifo_empty` & `rst` (combinational).
  - On the cycle `fifo_rd_en`=1, latch `fifo_rd_data` into the shift register, clear the bit counter, load the baud counter with `BAUD_DIV`-1, and go to START.
- Baud counter counts down. Each state holds for exactly `BAUD_DIV` cycles, and the state advances when the counter is 0.
- START: `tx`=0. Then go to DATA.
- DATA:
  - `tx` = shift register bit 0. At each bit end, shift right and increment the bit counter (width $clog2(S_WORD+1)).
  - After bit `S_WORD`-1, go to PARITY (if enabled) or STOP.
- STOP: `tx`=1 for `STOP_BITS`×`BAUD_DIV` cycles, then go to IDLE.
- `tx` and `busy` are registered. No combinational path from `fifo_empty` to `tx`.
- `fifo_rd_en` is never asserted outside IDLE, so exactly one pop occurs per frame. `fifo_empty` changes mid-frame have no effect.
- The word latched at pop time is transmitted unchanged. Later FIFO writes do not affect the frame in flight.

## Timing
- Reset (`rst`=0, asynchronously):
  - State IDLE, `tx`=1, `busy`=0, `fifo_rd_en`=0, counters and shift register 0.
  - Reset asserted mid-frame aborts the frame. `tx` returns high immediately and no further pop occurs until `rst` deasserts.
- Pop in cycle T: `tx` falls and `busy` rises at the edge ending T. The start bit occupies cycles T+1 … T+`BAUD_DIV`.
- Frame bit count N = 1 + `S_WORD` + P + `STOP_BITS` (P = 1 if parity enabled, else 0).
- `busy` stays high for N×`BAUD_DIV` cycles, then drops for at least one IDLE cycle.
- Back-to-back (FIFO non-empty): pops are spaced exactly N×`BAUD_DIV`+1 cycles apart. There is one extra idle-high cycle between frames.
- FIFO becoming non-empty in cycle T while IDLE: pop in the same cycle T, with zero added latency.

## Configuration
- `MIPS_UARTTX_PARITY_EN` defined:
  - PARITY state compiled in; P = 1.
  - `tx` = XOR of the latched `S_WORD` bits (even parity) for `BAUD_DIV` cycles, between the last data bit and stop.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

## Test plan
Bench settings: `S_WORD`=8, `BAUD_DIV`=4, `STOP_BITS`=1, parity off unless noted.

- Reset: hold `rst`=0 with `fifo_empty`=0 → `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout. First pop occurs in the first cycle after release.
- Single byte 0xA5:
  - One `fifo_rd_en` pulse.
  - `tx` sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - `busy` high for 40 cycles.
- Back-to-back 0x00, 0xFF with FIFO pre-loaded → two pops exactly 41 cycles apart, and both frames decode correctly.
- Parity (`MIPS_UARTTX_PARITY_EN`), byte 0x07 → parity bit 1, `busy` high 44 cycles. Byte 0x03 → parity bit 0.
- `STOP_BITS`=2, byte 0x55 → stop phase 8 cycles high, and the next pop comes 45 cycles after the first.
- Mid-frame reset: assert `rst`=0 during DATA bit 3 → `tx`=1 and `busy`=0 asynchronously. After release, the next FIFO word is sent as a full frame and no partial frame resumes.
